// File: rtl/bird_flight_ctrl.sv
// bird_flight_ctrl: debounced flap key to tick-paced fly/gravity strobes for the bird height FSM
module bird_flight_ctrl #(
    parameter int TICK_DIV  = 8,
    parameter int FLAP_ROWS = 3,
    parameter int DB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    input  logic mode,
    input  logic game_over,
    output logic fly,
    output logic gravity,
    output logic flapping
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {START, RUN, FLAP, OVER} state_t;

    state_t state, state_n;
    logic key_s1, key_s2, key_db, key_db_q;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] cnt, cnt_n;
    logic [3:0] rows_left, rows_n;
    logic fly_n, gravity_n, start_flap;
    logic press, tick, hold_up;

    assign press   = key_db & ~key_db_q;
    assign tick    = cnt == TICK_MAX;
    assign hold_up = mode & key_db;

    // two-flop synchronizer, then accept a new key level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s1   <= 1'b0;
            key_s2   <= 1'b0;
            key_db   <= 1'b0;
            key_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_db_q <= key_db;
            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // state, pacing counters and registered strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= START;
            cnt       <= '0;
            rows_left <= '0;
            fly       <= 1'b0;
            gravity   <= 1'b0;
            flapping  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rows_left <= rows_n;
            fly       <= fly_n;
            gravity   <= gravity_n;
            flapping  <= state_n == FLAP;
        end
    end

    // next state; strobes look ahead at the next counter value so each one lands on the edge its tick begins
    always_comb begin
        state_n    = state;
        cnt_n      = tick ? '0 : cnt + TW'(1);
        rows_n     = rows_left;
        start_flap = 1'b0;
        case (state)
            START, OVER: begin
                cnt_n = '0;
                if (press) begin
                    state_n    = mode ? RUN : FLAP;
                    start_flap = !mode;
                end
            end
            RUN: start_flap = press && !mode;
            FLAP: begin
                if (mode) begin
                    state_n = RUN;
                end else if (press) begin
                    start_flap = 1'b1;
                end else if (tick) begin
                    rows_n = rows_left - 4'd1;
                    if (rows_left == 4'd1) state_n = RUN;
                end
            end
            default: state_n = START;
        endcase
        if (start_flap) begin
            state_n = FLAP;
            cnt_n   = TICK_MAX;
            rows_n  = 4'(FLAP_ROWS);
        end
        if (game_over) begin
            state_n = OVER;
            cnt_n   = '0;
        end
        fly_n     = cnt_n == TICK_MAX && (state_n == FLAP || (state_n == RUN && hold_up));
        gravity_n = cnt_n == TICK_MAX && state_n == RUN && !hold_up;
    end
endmodule

// File: doc/bird_flight_ctrl.md
# bird_flight_ctrl

- Generates the one-cycle `fly` and `gravity` movement strobes that drive the bird height FSM.
- Converts the raw flap key into debounced, edge-qualified flap commands, with tap and hold play modes.
- Paces all movement with a programmable tick divider and freezes motion while `game_over` is high.
- Sits between the board key input and the bird height FSM. Its outputs connect directly to that FSM's `fly`/`gravity` inputs.

## Interface
Parameters:
- `TICK_DIV`, default 8: clock cycles between movement strobes; legal range ≥ 2.
- `FLAP_ROWS`, default 3: rows climbed per tap-mode flap; legal range 1–15.
- `DB_CYCLES`, default 4: consecutive stable synchronized samples required to change the debounced key; legal range ≥ 1.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `key`  in  1  raw flap button, 1 = pressed, asynchronous to `clock`.
- `mode`  in  1  0 = tap mode (press ⇒ flap burst); 1 = hold mode (held ⇒ rise, released ⇒ sink).
- `game_over`  in  1  level; freezes all motion while high.
- `fly`  out  1  one-cycle strobe: bird moves up one row.
- `gravity`  out  1  one-cycle strobe: bird moves down one row.
- `flapping`  out  1  high while a tap-mode flap burst is in progress.

## Operation
- **Input path:** `key` passes through a 2-flop synchronizer.
  - `key_db` takes the synchronized value after it differs from `key_db` for `DB_CYCLES` consecutive cycles. Any mismatch-free cycle clears the debounce counter.
  - `press` is a one-cycle pulse on each rising edge of `key_db`.
- **Tick counter:** counts 0..`TICK_DIV`-1 and wraps. `tick` = (count == `TICK_DIV`-1).
  - Held at 0 in START and OVER.
  - Loaded with `TICK_DIV`-1 on every flap start, so the first `fly` strobe comes on the next cycle.
- **States:** START, RUN, FLAP, OVER. Reset puts the block in START.
  - START: no strobes. `press` → FLAP in tap mode, → RUN in hold mode.
  - RUN, tap mode: `gravity` = `tick`. `press` → FLAP.
  - RUN, hold mode: on `tick`, `fly` if `key_db`, else `gravity`. `press` has no effect beyond `key_db`.
  - FLAP: `fly` = `tick`. Each `fly` decrements `rows_left`, which is loaded with `FLAP_ROWS` at flap start.
    - When the strobe that makes `rows_left` reach 0 fires, go to RUN.
    - A `press` during FLAP reloads `rows_left` and the tick counter (re-flap).
    - `mode` = 1 seen in FLAP → RUN immediately; the remaining rows are discarded.
  - Any state with `game_over` = 1 → OVER on the next edge; this has priority over everything.
  - OVER: no strobes. A `press` while `game_over` = 0 → FLAP (tap) or RUN (hold).
- **Invariants:**
  - `fly` and `gravity` are never high in the same cycle.
  - Each strobe is exactly 1 cycle wide.
  - Strobes are at least `TICK_DIV` cycles apart, except the first `fly` after a flap start. That strobe may follow the previous strobe after as little as 1 cycle.
- `mode` is sampled every cycle. A change takes effect at the next `tick` or `press`, except the FLAP case above.
- `flapping` = (state == FLAP).

## Timing
- Every output and internal register is registered and clears asynchronously on `reset`: `fly` = 0, `gravity` = 0, `flapping` = 0, state START, all counters 0, `key_db` = 0.
- Latency from `key` first sampled high (held stable) to `press`: 2 + `DB_CYCLES` clock edges.
  - First `fly` follows `press` by 1 more edge; `flapping` rises on the same edge.
  - With defaults that is 7 edges in total.
- `game_over` rising: strobes stop from the first edge after it is sampled. No strobe is issued in that edge's cycle.
- Reset asserted mid-flap: outputs drop immediately (asynchronous). After release, the block behaves exactly as after power-on.
- Key bounce shorter than `DB_CYCLES` cycles never produces `press`.

## Test plan
Defaults: `TICK_DIV` = 8, `FLAP_ROWS` = 3, `DB_CYCLES` = 4.
1. Reset, tap mode, hold `key` = 1 → `press` after 6 edges; `fly` pulses at edges 7, 15, 23 (3 pulses), `flapping` high throughout the burst; then `gravity` every 8 cycles.
2. Toggle `key` every 2 cycles for 20 cycles → no `press`; `fly` and `gravity` stay 0 in START.
3. Hold mode, RUN, `key` held 40 cycles then released → `fly` on each tick while held, `gravity` on each tick after `key_db` falls. Check `fly` & `gravity` never both 1.
4. Tap mode, second press lands after 2nd `fly` of a burst → `fly` next cycle, then 2 more fly strobes at 8-cycle spacing (3 fresh rows).
5. `game_over` = 1 during FLAP → no strobes from next edge on, state OVER. `game_over` = 0 plus press → new 3-row flap.
6. Assert `reset` for 1 cycle mid-flap → `fly`/`flapping` 0 immediately. With `key` held through reset, after release the block behaves as from power-on: debounce restarts from `key_db` = 0 and a new `press` fires 6 edges later.
